// File: rtl/dsp_nco_rom_sched.sv
// Multi-channel NCO controller. One sin/cos ROM is shared by NCH phase accumulators: each
// sweep issues one ROM address per cycle, and the returned samples are realigned with their channel.
module dsp_nco_rom_sched #(
  parameter int NCH        = 4,
  parameter int PHASE_W    = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int ROM_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [PHASE_W-1:0]      cfg_ftw,
  input  logic [ADDR_WIDTH-1:0]   cfg_pofs,
  input  logic                    cfg_en,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_sin,
  input  logic [DATA_WIDTH-1:0]   rom_cos,
  output logic                    out_valid,
  output logic [$clog2(NCH)-1:0]  out_ch,
  output logic [DATA_WIDTH-1:0]   out_sin,
  output logic [DATA_WIDTH-1:0]   out_cos,
  output logic                    busy,
  output logic                    overrun,
  output logic [1:0]              dbg_state
);

  localparam int CW         = $clog2(NCH);
  localparam int DCW        = $clog2(ROM_LAT + 2);
  localparam int DRAIN_LAST = ROM_LAT + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t                  state;
  logic [CW-1:0]           slot;
  logic [DCW-1:0]          dcnt;

  logic [PHASE_W-1:0]      ftw  [NCH];
  logic [PHASE_W-1:0]      acc  [NCH];
  logic [ADDR_WIDTH-1:0]   pofs [NCH];
  logic [NCH-1:0]          en;

  // Slot tags travel alongside the ROM access so data and channel id leave together.
  logic [ROM_LAT:0]        pv;
  logic [CW-1:0]           pch  [ROM_LAT+1];

  assign dbg_state = state;

  // tick is a strobe with no back-pressure: it is taken only in IDLE; any tick seen while a
  // sweep is running is dropped and reported by a one-cycle overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      rom_addr  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_sin   <= '0;
      out_cos   <= '0;
      pv        <= '0;
      en        <= '0;
      for (int i = 0; i < NCH; i++) begin
        ftw[i]  <= '0;
        acc[i]  <= '0;
        pofs[i] <= '0;
      end
      for (int i = 0; i <= ROM_LAT; i++) begin
        pch[i] <= '0;
      end
    end else begin
      overrun <= tick && (state != IDLE);
      pv[0]   <= 1'b0;

      case (state)
        IDLE: begin
          if (tick) begin
            state <= ISSUE;
            slot  <= '0;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          // Pre-increment phase addresses the ROM; a disabled channel still burns its slot.
          rom_addr <= acc[slot][PHASE_W-1 -: ADDR_WIDTH] + pofs[slot];
          pv[0]    <= en[slot];
          pch[0]   <= slot;
          if (en[slot]) begin
            acc[slot] <= acc[slot] + ftw[slot];
          end
          if (slot == CW'(NCH - 1)) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            slot <= slot + 1'b1;
          end
        end
        DRAIN: begin
          // Held until the last channel's sample has been presented on the outputs.
          if (dcnt == DCW'(DRAIN_LAST)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      for (int i = 1; i <= ROM_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pch[i] <= pch[i-1];
      end

      out_valid <= pv[ROM_LAT];
      if (pv[ROM_LAT]) begin
        out_ch  <= pch[ROM_LAT];
        out_sin <= rom_sin;
        out_cos <= rom_cos;
      end

      // Placed last so a write landing in its own channel's slot clears the accumulator
      // instead of letting that slot's increment through.
      if (cfg_we) begin
        ftw[cfg_ch]  <= cfg_ftw;
        pofs[cfg_ch] <= cfg_pofs;
        en[cfg_ch]   <= cfg_en;
        acc[cfg_ch]  <= '0;
      end
    end
  end

endmodule
